// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Walks the SCAN_RATE column slots of one rotor theta step. Each lit slot
// (col_mask bit set) captures one column per lane from the selected content
// source and holds it on cols_out until downstream accepts it. When the last
// slot is complete, frame_done pulses and the block waits for the next theta
// step. If theta moves before the scan finishes, overrun pulses and the scan
// restarts. A column that is already presented is never withdrawn because of
// this; the restart waits for its handshake.
//
// Ports
//   clk_in        sole clock, rising edge
//   rst_in        asynchronous, active-high reset
//   theta         current rotor angle step
//   mode          content source select, sampled at scan start only
//   col_mask      bit i set: slot i is lit at this theta
//   lookup_index  slot index presented to the content sources
//   lookup_cols   combinational source data for lookup_index, one per mode
//   cols_out      registered column data, one column per lane
//   col_num_out   physical column number per lane (slot + lane*SCAN_RATE)
//   out_valid     cols_out/col_num_out valid
//   out_ready     downstream accepts
//   frame_done    one-cycle pulse, scan of a theta step complete
//   overrun       one-cycle pulse, theta changed before scan complete
// -----------------------------------------------------------------------------
module frame_scheduler #(
   parameter int NUM_COLS     = 64,
   parameter int NUM_ROWS     = 64,
   parameter int NUM_CHANNELS = 2,
   parameter int SCAN_RATE    = NUM_COLS / NUM_CHANNELS,
   parameter int THETA_RES    = 8,
   parameter int RGB_RES      = 9,
   parameter int NUM_MODES    = 4
) (
   input  logic                                                        clk_in,
   input  logic                                                        rst_in,
   input  logic [THETA_RES-1:0]                                        theta,
   input  logic [$clog2(NUM_MODES)-1:0]                                mode,
   input  logic [SCAN_RATE-1:0]                                        col_mask,
   output logic [$clog2(SCAN_RATE)-1:0]                                lookup_index,
   input  logic [NUM_MODES-1:0][NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] lookup_cols,
   output logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0]          cols_out,
   output logic [NUM_CHANNELS-1:0][$clog2(NUM_COLS)-1:0]               col_num_out,
   output logic                                                        out_valid,
   input  logic                                                        out_ready,
   output logic                                                        frame_done,
   output logic                                                        overrun
);

   localparam int IDX_W  = $clog2(SCAN_RATE);
   localparam int COL_W  = $clog2(NUM_COLS);
   localparam int MODE_W = $clog2(NUM_MODES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]                                         r_state;
   logic [IDX_W-1:0]                                   r_idx;
   logic [THETA_RES-1:0]                               r_theta_q;
   logic [MODE_W-1:0]                                  r_mode_q;
   logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] r_cols;
   logic [NUM_CHANNELS-1:0][COL_W-1:0]                 r_col_num;
   logic                                               r_valid;
   logic                                               r_frame_done;
   logic                                               r_overrun;
   logic                                               r_restart_pend;

   logic w_theta_chg;
   logic w_last;
   logic w_lit;
   logic w_handshake;
   logic w_start;
   logic w_complete;
   logic w_overrun;

   assign w_theta_chg = (theta != r_theta_q);
   assign w_last      = (r_idx == IDX_W'(SCAN_RATE - 1));
   assign w_lit       = col_mask[r_idx];
   // r_valid is only ever set in HOLD, so this is the HOLD handshake.
   assign w_handshake = r_valid && out_ready;

   // Per-edge decisions: start a new scan, finish the current one, report overrun.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      w_start    = 1'b0;
      w_complete = 1'b0;
      w_overrun  = 1'b0;
      case (r_state)
         ST_IDLE: w_start = 1'b1;
         ST_SCAN: begin
            // Finishing the last slot wins over a theta change on the same edge.
            w_complete = w_last && !w_lit;
            w_start    = w_theta_chg && !w_complete;
            w_overrun  = w_start;
         end
         ST_HOLD: begin
            w_complete = w_handshake && w_last;
            // A held column is never dropped: a restart waits for its handshake,
            // and the theta change behind it is reported exactly once.
            w_start    = w_handshake && !w_last && (r_restart_pend || w_theta_chg);
            w_overrun  = w_theta_chg && !r_restart_pend && !w_complete;
         end
         ST_DONE: w_start = w_theta_chg;
         default: w_start = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state        <= ST_IDLE;
         r_idx          <= '0;
         r_theta_q      <= '0;
         r_mode_q       <= '0;
         // NOTE: the column datapath is reset as well, so cols_out reads zero while rst_in is high.
         r_cols         <= '0;
         r_col_num      <= '0;
         r_valid        <= 1'b0;
         r_frame_done   <= 1'b0;
         r_overrun      <= 1'b0;
         r_restart_pend <= 1'b0;
      end else begin
         r_frame_done   <= w_complete;
         r_overrun      <= w_overrun;
         r_restart_pend <= (r_state == ST_HOLD) && !w_handshake && (r_restart_pend || w_theta_chg);

         if (w_handshake) begin
            r_valid <= 1'b0;
         end

         if (w_start) begin
            r_state   <= ST_SCAN;
            r_theta_q <= theta;
            r_mode_q  <= mode;
            r_idx     <= '0;
         end else begin
            case (r_state)
               ST_SCAN: begin
                  if (w_complete) begin
                     r_state <= ST_DONE;
                  end else if (w_lit) begin
                     r_cols  <= lookup_cols[r_mode_q];
                     for (int k = 0; k < NUM_CHANNELS; k++) begin
                        r_col_num[k] <= COL_W'(r_idx) + COL_W'(k * SCAN_RATE);
                     end
                     r_valid <= 1'b1;
                     r_state <= ST_HOLD;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
               ST_HOLD: begin
                  if (w_complete) begin
                     // idx stays on the last slot; it never wraps within a scan.
                     r_state <= ST_DONE;
                  end else if (w_handshake) begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_state <= ST_SCAN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign lookup_index = r_idx;
   assign cols_out     = r_cols;
   assign col_num_out  = r_col_num;
   assign out_valid    = r_valid;
   assign frame_done   = r_frame_done;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//
// Scoreboard bench for frame_scheduler. Content sources are a deterministic
// pixel function of (mode, slot, lane, row); each expected column is pushed
// when its stimulus is applied and popped when the DUT hands it off. A second
// instance with four lanes over 128 columns checks the per-lane column math.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

   localparam int NUM_COLS     = 64;
   localparam int NUM_ROWS     = 64;
   localparam int NUM_CHANNELS = 2;
   localparam int SCAN_RATE    = 32;
   localparam int THETA_RES    = 8;
   localparam int RGB_RES      = 9;
   localparam int NUM_MODES    = 4;
   localparam int MODE_W       = 2;
   localparam int IDX_W        = 5;
   localparam int COL_W        = 6;

   localparam int W_COLS  = 128;
   localparam int W_CH    = 4;
   localparam int W_ROWS  = 2;
   localparam int W_COL_W = 7;

   typedef logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] cols_t;
   typedef struct {
      int     c0;
      int     c1;
      longint csum;
   } exp_t;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic                                                        rst_in;
   logic [THETA_RES-1:0]                                        theta;
   logic [MODE_W-1:0]                                           mode;
   logic [SCAN_RATE-1:0]                                        col_mask;
   logic [IDX_W-1:0]                                            lookup_index;
   logic [NUM_MODES-1:0][NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] lookup_cols;
   cols_t                                                       cols_out;
   logic [NUM_CHANNELS-1:0][COL_W-1:0]                          col_num_out;
   logic                                                        out_valid;
   logic                                                        out_ready;
   logic                                                        frame_done;
   logic                                                        overrun;

   logic                                                        rst_w;
   logic [THETA_RES-1:0]                                        theta_w;
   logic [MODE_W-1:0]                                           mode_w;
   logic [SCAN_RATE-1:0]                                        mask_w;
   logic [IDX_W-1:0]                                            lookup_index_w;
   logic [NUM_MODES-1:0][W_CH-1:0][W_ROWS-1:0][RGB_RES-1:0]     lookup_cols_w;
   logic [W_CH-1:0][W_ROWS-1:0][RGB_RES-1:0]                    cols_out_w;
   logic [W_CH-1:0][W_COL_W-1:0]                                col_num_out_w;
   logic                                                        out_valid_w;
   logic                                                        frame_done_w;
   logic                                                        overrun_w;

   frame_scheduler dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .theta        (theta),
      .mode         (mode),
      .col_mask     (col_mask),
      .lookup_index (lookup_index),
      .lookup_cols  (lookup_cols),
      .cols_out     (cols_out),
      .col_num_out  (col_num_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .frame_done   (frame_done),
      .overrun      (overrun)
   );

   frame_scheduler #(
      .NUM_COLS     (W_COLS),
      .NUM_ROWS     (W_ROWS),
      .NUM_CHANNELS (W_CH)
   ) dut_wide (
      .clk_in       (clk_in),
      .rst_in       (rst_w),
      .theta        (theta_w),
      .mode         (mode_w),
      .col_mask     (mask_w),
      .lookup_index (lookup_index_w),
      .lookup_cols  (lookup_cols_w),
      .cols_out     (cols_out_w),
      .col_num_out  (col_num_out_w),
      .out_valid    (out_valid_w),
      .out_ready    (1'b1),
      .frame_done   (frame_done_w),
      .overrun      (overrun_w)
   );

   assign lookup_cols_w = '0;

   exp_t sb_q[$];
   int   n_vec     = 0;
   int   n_bad     = 0;
   int   cyc       = 0;
   int   fd_cnt    = 0;
   int   ov_cnt    = 0;
   int   exp_idx_w = 0;

   always @(posedge clk_in) cyc++;

   // Content model: distinct, position-dependent pixel per (mode, slot, lane, row).
   function automatic logic [RGB_RES-1:0] pix(input int m, input int i, input int k, input int r);
      return RGB_RES'((m * 131 + i * 17 + k * 7 + r * 3 + 1) % 512);
   endfunction

   always_comb begin
      lookup_cols = '0;
      for (int m = 0; m < NUM_MODES; m++)
         for (int k = 0; k < NUM_CHANNELS; k++)
            for (int r = 0; r < NUM_ROWS; r++)
               lookup_cols[m][k][r] = pix(m, int'(lookup_index), k, r);
   end

   // Position-weighted sum, so swapped lanes or rows change the result.
   function automatic longint csum_obs(input cols_t c);
      longint s = 0;
      for (int k = 0; k < NUM_CHANNELS; k++)
         for (int r = 0; r < NUM_ROWS; r++)
            s += longint'(k * NUM_ROWS + r + 1) * longint'(c[k][r]);
      return s;
   endfunction

   function automatic longint csum_exp(input int m, input int i);
      longint s = 0;
      for (int k = 0; k < NUM_CHANNELS; k++)
         for (int r = 0; r < NUM_ROWS; r++)
            s += longint'(k * NUM_ROWS + r + 1) * longint'(pix(m, i, k, r));
      return s;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_col(input int m, input int i);
      exp_t e;
      e.c0   = i;
      e.c1   = i + SCAN_RATE;
      e.csum = csum_exp(m, i);
      sb_q.push_back(e);
   endtask

   task automatic push_scan(input int m, input logic [SCAN_RATE-1:0] mask);
      for (int i = 0; i < SCAN_RATE; i++)
         if (mask[i]) push_col(m, i);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic wait_fd(input string tag, input int budget, output int at_cyc);
      bit seen = 1'b0;
      at_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (frame_done) begin
            seen   = 1'b1;
            at_cyc = cyc;
            break;
         end
      end
      check({tag, "_frame_done_seen"}, 64'(seen), 1);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_valid_seen"}, 64'(seen), 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"},  64'(out_valid), 0);
      check({tag, "_fdone"},  64'(frame_done), 0);
      check({tag, "_ovr"},    64'(overrun), 0);
      check({tag, "_idx"},    64'(lookup_index), 0);
      check({tag, "_col0"},   64'(col_num_out[0]), 0);
      check({tag, "_col1"},   64'(col_num_out[1]), 0);
      check({tag, "_pixels"}, 64'(csum_obs(cols_out)), 0);
   endtask

   // Output monitor: samples on the falling edge, pops one expectation per handshake.
   always @(negedge clk_in) begin
      exp_t e;
      if (!rst_in) begin
         if (frame_done) fd_cnt++;
         if (overrun) ov_cnt++;
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("lane0_col", 64'(col_num_out[0]), 64'(e.c0));
               check("lane1_col", 64'(col_num_out[1]), 64'(e.c1));
               check("pixels", 64'(csum_obs(cols_out)), 64'(e.csum));
            end
         end
      end
   end

   always @(negedge clk_in) begin
      if (!rst_w && out_valid_w) begin
         for (int k = 0; k < W_CH; k++)
            check("wide_lane_col", 64'(col_num_out_w[k]), 64'(exp_idx_w + k * 32));
         exp_idx_w++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      int t0;
      int t_fd;
      int fd0;
      int ov0;

      rst_in    = 1'b1;
      rst_w     = 1'b1;
      theta     = '0;
      mode      = '0;
      col_mask  = '1;
      out_ready = 1'b1;
      theta_w   = '0;
      mode_w    = '0;
      mask_w    = '1;
      #12;
      check_zero("reset");

      // Full mask, fixed theta: 32 columns in order, one frame_done.
      push_scan(0, '1);
      fd0 = fd_cnt; ov0 = ov_cnt;
      @(negedge clk_in);
      rst_in = 1'b0;
      rst_w  = 1'b0;
      wait_fd("full", 200, t_fd);
      step(4);
      check("full_fd_count", 64'(fd_cnt - fd0), 1);
      check("full_ovr_count", 64'(ov_cnt - ov0), 0);
      check("full_sb_left", 64'(sb_q.size()), 0);

      // First and last slot only, source 1.
      fd0 = fd_cnt;
      push_col(1, 0);
      push_col(1, 31);
      col_mask = 32'h8000_0001;
      mode     = 2'd1;
      theta    = 8'd1;
      t0       = cyc;
      wait_fd("ends", 100, t_fd);
      check("ends_fd_latency", 64'(t_fd - (t0 + 1)), 34);
      step(2);
      check("ends_fd_count", 64'(fd_cnt - fd0), 1);
      check("ends_sb_left", 64'(sb_q.size()), 0);

      // Mode change mid-scan must not affect the running scan.
      push_scan(0, '1);
      col_mask = '1;
      mode     = 2'd0;
      theta    = 8'd2;
      step(10);
      mode = 2'd2;
      wait_fd("mode_hold", 200, t_fd);
      step(1);
      push_scan(2, 32'h0000_00F0);
      col_mask = 32'h0000_00F0;
      theta    = 8'd3;
      wait_fd("mode_next", 100, t_fd);
      check("mode_sb_left", 64'(sb_q.size()), 0);

      // Stall with valid high while theta moves: stable output, one overrun,
      // restart only after the held column is accepted.
      step(1);
      ov0 = ov_cnt;
      push_col(3, 1);
      col_mask  = 32'h0000_0006;
      mode      = 2'd3;
      out_ready = 1'b0;
      theta     = 8'd4;
      wait_valid("stall", 40);
      for (int c = 0; c < 10; c++) begin
         step(1);
         if (c == 2) theta = 8'd5;
         @(negedge clk_in);
         check("stall_valid", 64'(out_valid), 1);
         check("stall_col0", 64'(col_num_out[0]), 1);
         check("stall_col1", 64'(col_num_out[1]), 33);
         check("stall_idx", 64'(lookup_index), 1);
         check("stall_pixels", 64'(csum_obs(cols_out)), 64'(csum_exp(3, 1)));
      end
      check("stall_ovr_count", 64'(ov_cnt - ov0), 1);
      push_col(3, 1);
      push_col(3, 2);
      fd0 = fd_cnt;
      step(1);
      out_ready = 1'b1;
      wait_fd("stall", 120, t_fd);
      step(1);
      check("stall_ovr_final", 64'(ov_cnt - ov0), 1);
      check("stall_fd_count", 64'(fd_cnt - fd0), 1);
      check("stall_sb_left", 64'(sb_q.size()), 0);

      // Theta change while scanning: one overrun, scan restarts.
      ov0 = ov_cnt; fd0 = fd_cnt;
      push_col(1, 31);
      col_mask = 32'h8000_0000;
      mode     = 2'd1;
      theta    = 8'd6;
      step(5);
      theta = 8'd7;
      wait_fd("scan_ovr", 100, t_fd);
      step(1);
      check("scan_ovr_count", 64'(ov_cnt - ov0), 1);
      check("scan_ovr_fd", 64'(fd_cnt - fd0), 1);
      check("scan_ovr_sb_left", 64'(sb_q.size()), 0);

      // Empty mask: exactly SCAN_RATE cycles; theta change on the completing
      // edge counts as completion, then a fresh scan follows from DONE.
      ov0 = ov_cnt; fd0 = fd_cnt;
      col_mask = '0;
      theta    = 8'd9;
      t0       = cyc;
      step(32);
      theta = 8'd10;
      wait_fd("empty", 10, t_fd);
      check("empty_fd_latency", 64'(t_fd - (t0 + 1)), 32);
      check("edge_ovr_now", 64'(overrun), 0);
      wait_fd("edge_rescan", 60, t_fd);
      step(1);
      check("edge_fd_count", 64'(fd_cnt - fd0), 2);
      check("edge_ovr_count", 64'(ov_cnt - ov0), 0);

      // Asynchronous reset while a column is held.
      col_mask  = '1;
      mode      = 2'd0;
      out_ready = 1'b0;
      theta     = 8'd8;
      wait_valid("rst_hold", 40);
      #2;
      rst_in = 1'b1;
      #1;
      check_zero("rst_hold");
      #1;
      rst_in    = 1'b0;
      col_mask  = 32'h0000_0003;
      out_ready = 1'b1;
      push_col(0, 0);
      push_col(0, 1);
      @(negedge clk_in);
      check("rst_restart_idx", 64'(lookup_index), 0);
      check("rst_restart_valid", 64'(out_valid), 0);
      wait_fd("rst_restart", 100, t_fd);
      step(1);
      check("rst_sb_left", 64'(sb_q.size()), 0);

      check("wide_outputs", 64'(exp_idx_w), 32);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- NUM_COLS, 64, physical columns per panel
- NUM_ROWS, 64, LEDs per column
- NUM_CHANNELS, 2, column lanes driven in parallel (power of 2, divides NUM_COLS)
- SCAN_RATE, NUM_COLS/NUM_CHANNELS, column slots scanned per theta step
- THETA_RES, 8, theta width
- RGB_RES, 9, bits per pixel
- NUM_MODES, 4, selectable content sources
REQ-002 Ports, one per line: name  direction  width  meaning:
- clk_in  in  1  sole clock, all state on rising edge
- rst_in  in  1  asynchronous, active-high reset
- theta  in  THETA_RES  current rotor angle step
- mode  in  $clog2(NUM_MODES)  content source select
- col_mask  in  SCAN_RATE  bit i=1: slot i is lit at this theta
- lookup_index  out  $clog2(SCAN_RATE)  slot index presented to content sources
- lookup_cols  in  NUM_MODES x NUM_CHANNELS x NUM_ROWS x RGB_RES  combinational source data for lookup_index
- cols_out  out  NUM_CHANNELS x NUM_ROWS x RGB_RES  registered column data
- col_num_out  out  NUM_CHANNELS x $clog2(NUM_COLS)  physical column per lane
- out_valid  out  1  cols_out/col_num_out valid
- out_ready  in  1  downstream accepts
- frame_done  out  1  one-cycle pulse, scan of a theta step complete
- overrun  out  1  one-cycle pulse, theta changed before scan complete
REQ-003 Clock and reset: one clock clk_in; reset rst_in asynchronous, active-high.

Function
REQ-004 States: IDLE, SCAN, HOLD, DONE; encoding free.
REQ-005 theta_q register holds theta sampled at scan start; theta change = (theta != theta_q).
REQ-006 IDLE (first cycle after reset release): unconditionally start scan: theta_q<=theta, mode_q<=mode, idx<=0, go SCAN.
REQ-007 mode_q latched only at scan start; mode changes mid-scan have no effect until next scan.
REQ-008 lookup_index = idx at all times; content selected from lookup_cols[mode_q].
REQ-009 SCAN, col_mask[idx]=0: idx<=idx+1 one slot per cycle, no output.
REQ-010 SCAN, col_mask[idx]=1: capture cols_out<=lookup_cols[mode_q], col_num_out[k]<=idx+k*SCAN_RATE for every lane k, out_valid<=1, go HOLD; latency one cycle from slot evaluation to out_valid.
REQ-011 HOLD: out_valid, cols_out, col_num_out stable until out_valid&&out_ready; on handshake out_valid<=0 same edge, idx advances, return SCAN.
REQ-012 Last slot (idx=SCAN_RATE-1) completed (masked-off or handshaken): go DONE, frame_done pulses 1 cycle; idx never wraps within one scan.
REQ-013 DONE: on theta change start new scan as REQ-006 (no overrun pulse).
REQ-014 Theta change in SCAN: overrun pulses 1 cycle, scan restarts as REQ-006 next edge.
REQ-015 Theta change in HOLD: overrun pulses once; restart deferred until handshake completes; valid never dropped without handshake.
REQ-016 Theta change coincident with last-slot completion: treat as completion (frame_done=1, overrun=0), then restart from DONE next cycle.
REQ-017 col_mask all-zero: scan takes exactly SCAN_RATE cycles, no out_valid, frame_done pulses.
REQ-018 col_num_out arithmetic in $clog2(NUM_COLS) bits; no truncation for legal parameters.

Reset
REQ-019 While rst_in=1 (asynchronously): state IDLE, idx 0, theta_q 0, mode_q 0, cols_out 0, col_num_out all 0, out_valid 0, frame_done 0, overrun 0.
REQ-020 Reset asserted mid-HOLD aborts the pending column; no handshake required.

Verification
REQ-021 Defaults, col_mask=all-ones, out_ready=1, theta fixed: 32 valid outputs, lane0 col 0..31, lane1 col 32..63, frame_done once.
REQ-022 col_mask=0x8000_0001, out_ready=1: exactly two outputs (lane0 col 0 and 31, lane1 col 32 and 63); frame_done 32..34 cycles after scan start.
REQ-023 out_ready=0 for 10 cycles with valid high, theta changes meanwhile: outputs stable, overrun one pulse, restart only after out_ready=1 handshake.
REQ-024 mode toggled 0->2 mid-scan: remaining columns still from source 0; next theta step uses source 2.
REQ-025 rst_in pulsed mid-HOLD without clock edge: all outputs 0 immediately; scan restarts at idx 0 after release.
REQ-026 Parameter sweep NUM_CHANNELS=4, NUM_COLS=128: lane k col_num = idx+k*32 for all k.
